fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction fetch stage placed directly upstream of the CPU fetch/decode unit.
- Reads instruction bytes from a byte-wide synchronous memory.
- Assembles opcode plus up to 2 operand bytes using a built-in length table.
- Hands the complete instruction to the CPU over a valid/ready handshake.
- Accepts a redirect from the CPU for jumps and flushes any partly fetched instruction.

Parameters:
ADDR_W, 16, width of program counter and memory address (matches addr_t)
RESET_PC, 16'h0000, fetch address loaded on reset

Ports:
clk  in  1  system clock; all state changes on posedge
reset_n  in  1  synchronous active-low reset, sampled on posedge clk
mem_rd  out  1  memory read strobe, valid this cycle
mem_addr  out  ADDR_W  memory read address, valid while mem_rd=1
mem_rdata  in  8  read data; valid in the cycle after the mem_rd cycle (1-cycle latency)
instr_valid  out  1  assembled instruction available
instr_ready  in  1  CPU accepts the instruction this cycle
instr_pc  out  ADDR_W  address of the opcode byte
instr_opcode  out  8  opcode byte
instr_op1  out  8  first operand byte (0 if len<2)
instr_op2  out  8  second operand byte (0 if len<3)
instr_len  out  2  instruction length in bytes, 1..3
redirect  in  1  CPU requests a fetch restart
redirect_pc  in  ADDR_W  new fetch address when redirect=1

Behaviour:
- Reset (reset_n=0 at posedge):
  - state=ISSUE, fp=RESET_PC.
  - instr_valid=0, instr_pc=0, instr_opcode=0, instr_op1=0, instr_op2=0, instr_len=1.
  - mem_rd=0 during the reset cycle.
  - Reset mid-fetch or mid-hold discards everything.
- Length table, from the opcode byte:
  - A2, A9 -> 2
  - 4C, 8D -> 3
  - E8, EA -> 1
  - all other opcodes -> 1 (treated as implied)
- Internal fetch pointer fp (ADDR_W bits): increments after each byte read is issued and wraps FFFF->0000 with no flag.
- ISSUE:
  - mem_rd=1, mem_addr=fp, fp<=fp+1.
  - Register instr_pc<=fp.
  - Next state: CAP_OPC.
- CAP_OPC:
  - instr_opcode<=mem_rdata, instr_len<=table(mem_rdata), instr_op1<=0, instr_op2<=0.
  - If len>1: mem_rd=1, mem_addr=fp, fp<=fp+1, next state CAP_OP1.
  - Otherwise: next state HOLD.
- CAP_OP1:
  - instr_op1<=mem_rdata.
  - If len=3: issue read of fp, fp<=fp+1, next state CAP_OP2.
  - Otherwise: next state HOLD.
- CAP_OP2: instr_op2<=mem_rdata; next state HOLD.
- HOLD:
  - instr_valid=1 (registered; asserted on the HOLD entry edge).
  - Outputs stay stable while instr_ready=0.
  - On instr_valid&&instr_ready: instr_valid<=0, next state ISSUE. fp already points to instr_pc+len.
- Latency from entering ISSUE to instr_valid high:
  - len 1: 2 cycles.
  - len 2: 3 cycles.
  - len 3: 4 cycles.
- mem_rd is 0 in HOLD, and in CAP states that need no further byte.
- Redirect has the highest priority below reset, in any state:
  - fp<=redirect_pc, state<=ISSUE, instr_valid<=0.
  - Read data still in flight is ignored.
  - mem_rd=0 in the redirect cycle.
- Redirect in the same cycle as a handshake: the instruction counts as consumed, and the redirect still takes effect.
- instr_ready while instr_valid=0 is ignored.

Optional Feature:
FETCH_OVERLAP_EN
- Defined: in HOLD, a handshake cycle also performs the ISSUE action (mem_rd=1, mem_addr=fp, instr_pc<=fp, fp<=fp+1) and goes straight to CAP_OPC. This saves 1 cycle per back-to-back instruction.
- A redirect in that cycle suppresses the overlap: mem_rd=0, the redirect rule applies.
- Undefined: behaviour exactly as in Behaviour; the handshake returns to ISSUE.

Test Plan:
- Reset with RESET_PC=0, memory[0]=E8, instr_ready=1 -> mem_rd at cycle 1 with addr 0000; instr_valid at cycle 3 with opcode E8, len 1, pc 0000.
- Memory A2 05 E8 from 0000, ready=1 -> first instr: opcode A2, op1 05, len 2, pc 0000; second: opcode E8, pc 0002; op1 and op2 read as 00.
- Memory 8D 34 12 at 0010 with redirect to 0010 -> opcode 8D, op1 34, op2 12, len 3, pc 0010; fp becomes 0013.
- instr_ready held 0 for 5 cycles in HOLD -> outputs stable, instr_valid=1, mem_rd=0 throughout; release -> single handshake, then next fetch at instr_pc+len.
- redirect=1, redirect_pc=0100 during CAP_OP1 of an A9 instruction -> no instr_valid for it; next delivered instr has pc 0100.
- With FETCH_OVERLAP_EN and stream E8 E8 E8 under constant ready -> valid every 2 cycles; without the macro -> valid every 3 cycles.
- Stream ending at FFFF, memory[FFFF]=A9, memory[0000]=07 -> op1=07; fp wraps to 0001.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: byte-wide memory read port, instruction handshake to the CPU,
// and the CPU redirect request. The fetch unit uses "master", its environment "slave".
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;

    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] instr_pc;
    logic [7:0]        instr_opcode;
    logic [7:0]        instr_op1;
    logic [7:0]        instr_op2;
    logic [1:0]        instr_len;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output mem_rd, mem_addr,
        input  mem_rdata,
        output instr_valid, instr_pc, instr_opcode, instr_op1, instr_op2, instr_len,
        input  instr_ready,
        input  redirect, redirect_pc
    );

    modport slave (
        input  mem_rd, mem_addr,
        output mem_rdata,
        input  instr_valid, instr_pc, instr_opcode, instr_op1, instr_op2, instr_len,
        output instr_ready,
        output redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: reads opcode plus up to two operand bytes from a byte-wide
// synchronous memory (1-cycle read latency), holds the assembled instruction on a
// valid/ready handshake, and restarts fetching on a CPU redirect.
// Optional feature macro FETCH_OVERLAP_EN: a handshake in HOLD also issues the next opcode
// read, saving one cycle per back-to-back instruction.
module fetch_unit #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          reset_n,
    fetch_unit_if.master bus
);

    typedef enum logic [2:0] {
        StIssue,
        StCapOpc,
        StCapOp1,
        StCapOp2,
        StHold
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fp_q, fp_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        opc_q, opc_d;
    logic [7:0]        op1_q, op1_d;
    logic [7:0]        op2_q, op2_d;
    logic [1:0]        len_q, len_d;
    logic              valid_q, valid_d;
    logic              rd;
    logic              handshake;
    logic [1:0]        rdata_len;

    // Unknown opcodes are treated as 1-byte implied instructions.
    function automatic logic [1:0] len_lookup(input logic [7:0] opc);
        case (opc)
            8'hA2, 8'hA9: len_lookup = 2'd2;
            8'h4C, 8'h8D: len_lookup = 2'd3;
            default:      len_lookup = 2'd1;
        endcase
    endfunction

    assign rdata_len = len_lookup(bus.mem_rdata);
    assign handshake = valid_q && bus.instr_ready;

    // Next-state, fetch pointer and captured-field updates; read strobe decode.
    always_comb begin
        state_d = state_q;
        fp_d    = fp_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        len_d   = len_q;
        valid_d = valid_q;
        rd      = 1'b0;

        if (bus.redirect) begin
            // Any in-flight read data is simply never captured after this.
            fp_d    = bus.redirect_pc;
            state_d = StIssue;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIssue: begin
                    rd      = 1'b1;
                    fp_d    = fp_q + ADDR_W'(1);
                    pc_d    = fp_q;
                    state_d = StCapOpc;
                end
                StCapOpc: begin
                    opc_d = bus.mem_rdata;
                    len_d = rdata_len;
                    op1_d = 8'h00;
                    op2_d = 8'h00;
                    if (rdata_len > 2'd1) begin
                        rd      = 1'b1;
                        fp_d    = fp_q + ADDR_W'(1);
                        state_d = StCapOp1;
                    end else begin
                        state_d = StHold;
                        valid_d = 1'b1;
                    end
                end
                StCapOp1: begin
                    op1_d = bus.mem_rdata;
                    if (len_q == 2'd3) begin
                        rd      = 1'b1;
                        fp_d    = fp_q + ADDR_W'(1);
                        state_d = StCapOp2;
                    end else begin
                        state_d = StHold;
                        valid_d = 1'b1;
                    end
                end
                StCapOp2: begin
                    op2_d   = bus.mem_rdata;
                    state_d = StHold;
                    valid_d = 1'b1;
                end
                StHold: begin
                    if (handshake) begin
                        valid_d = 1'b0;
`ifdef FETCH_OVERLAP_EN
                        rd      = 1'b1;
                        fp_d    = fp_q + ADDR_W'(1);
                        pc_d    = fp_q;
                        state_d = StCapOpc;
`else
                        state_d = StIssue;
`endif
                    end
                end
                default: state_d = StIssue;
            endcase
        end
    end

    // State and captured-instruction registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIssue;
            fp_q    <= RESET_PC;
            pc_q    <= '0;
            opc_q   <= 8'h00;
            op1_q   <= 8'h00;
            op2_q   <= 8'h00;
            len_q   <= 2'd1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fp_q    <= fp_d;
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            len_q   <= len_d;
            valid_q <= valid_d;
        end
    end

    // No read strobe while reset is asserted, whatever the state register holds.
    assign bus.mem_rd       = rd && reset_n;
    assign bus.mem_addr     = fp_q;
    assign bus.instr_valid  = valid_q;
    assign bus.instr_pc     = pc_q;
    assign bus.instr_opcode = opc_q;
    assign bus.instr_op1    = op1_q;
    assign bus.instr_op2    = op2_q;
    assign bus.instr_len    = len_q;

endmodule
